hazard_controller: RTL

Central pipeline sequencer for the 5-stage processor. It tracks EX/MEM/WB destination registers in an internal 3-entry scoreboard, generates the ID-stage branch-operand forwarding selects, and detects load-use and branch-operand hazards to stall the front end. It also pulses the IF flush on taken branches or jumps, and drains and halts the pipeline on `terminate`. It sits beside ID_stage, drives that stage's `stall`, `branch_a1_sel` and `branch_a2_sel` inputs, and drives the PC and IF/ID register enables.

---
 rtl/hazard_controller_if.sv | 38 +++
 rtl/hazard_controller.sv | 112 +++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// ID-stage hazard bundle: decoded operand/destination info flows in,
// stall, forwarding, flush and front-end enable controls flow back out.
interface hazard_controller_if;
    logic [4:0]  reg_rs;
    logic [4:0]  reg_rt;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic [4:0]  reg_dest;
    logic        id_wb_en;
    logic        id_mem_r;
    logic        is_branch;
    logic        branch_taken;
    logic        jump_taken;
    logic        terminate;
    logic        stall;
    logic        pc_en;
    logic        ifid_en;
    logic        ex_bubble;
    logic        if_flush;
    logic [1:0]  branch_a1_sel;
    logic [1:0]  branch_a2_sel;
    logic        halted;
    logic [15:0] stall_cycles;

    modport master (
        output reg_rs, reg_rt, instr_rs, instr_rt, reg_dest,
        output id_wb_en, id_mem_r, is_branch, branch_taken, jump_taken, terminate,
        input  stall, pc_en, ifid_en, ex_bubble, if_flush,
        input  branch_a1_sel, branch_a2_sel, halted, stall_cycles
    );

    modport slave (
        input  reg_rs, reg_rt, instr_rs, instr_rt, reg_dest,
        input  id_wb_en, id_mem_r, is_branch, branch_taken, jump_taken, terminate,
        output stall, pc_en, ifid_en, ex_bubble, if_flush,
        output branch_a1_sel, branch_a2_sel, halted, stall_cycles
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer: EX/MEM/WB destination scoreboard, ID branch-operand forwarding,
// load-use / branch-operand stalls, IF flush on redirects, and terminate drain/halt.
module hazard_controller #(
    parameter int DRAIN_CYCLES = 3
) (
    input logic                clk,
    input logic                rst,
    hazard_controller_if.slave hz
);
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_r;
    } sb_entry_t;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    sb_entry_t   ex_q, mem_q, wb_q, ex_d;
    state_t      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        run, hold, s1, s2, s3, ex_bubble;

    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
        return e.valid && e.wb_en && (e.dest == r) && (r != 5'd0);
    endfunction

    // Loads in EX/MEM never forward; the stall logic holds the branch instead.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input sb_entry_t ex,
                                           input sb_entry_t mem, input sb_entry_t wb);
        if (sb_match(ex, r) && !ex.mem_r)        return 2'd1;
        else if (sb_match(mem, r) && !mem.mem_r) return 2'd2;
        else if (sb_match(wb, r))                return 2'd3;
        else                                     return 2'd0;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        run = (state_q == ST_RUN);
        s1  = !hz.is_branch && ex_q.mem_r &&
              (sb_match(ex_q, hz.reg_rs) || sb_match(ex_q, hz.reg_rt));
        s2  = hz.is_branch && ex_q.mem_r &&
              (sb_match(ex_q, hz.instr_rs) || sb_match(ex_q, hz.instr_rt));
        s3  = hz.is_branch && mem_q.mem_r &&
              (sb_match(mem_q, hz.instr_rs) || sb_match(mem_q, hz.instr_rt));
        hold      = run && (s1 || s2 || s3);
        ex_bubble = hold || !run;
    end

    always_comb begin
        ex_d = '0;
        if (!ex_bubble) begin
            ex_d.valid = 1'b1;
            ex_d.dest  = hz.reg_dest;
            ex_d.wb_en = hz.id_wb_en;
            ex_d.mem_r = hz.id_mem_r;
        end

        stall_cnt_d = hold ? sat_inc(stall_cnt_q) : stall_cnt_q;

        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (hz.terminate && !hold) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) state_d = ST_HALTED;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    assign hz.stall         = hold;
    assign hz.pc_en         = run && !hold;
    assign hz.ifid_en       = run && !hold;
    assign hz.ex_bubble     = ex_bubble;
    assign hz.if_flush      = run && !hold && !hz.terminate && (hz.branch_taken || hz.jump_taken);
    assign hz.branch_a1_sel = fwd_sel(hz.instr_rs, ex_q, mem_q, wb_q);
    assign hz.branch_a2_sel = fwd_sel(hz.instr_rt, ex_q, mem_q, wb_q);
    assign hz.halted        = (state_q == ST_HALTED);
    assign hz.stall_cycles  = stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= ST_RUN;
            drain_q     <= 2'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            wb_q        <= mem_q;
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
